// File: rtl/demux32_1_8_buf_if.sv
// Bus bundle for the 1-to-8 steering block.
// master = producer/consumer side, slave = the steering block itself.
interface demux32_1_8_buf_if #(
    parameter int DATA_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [2:0]            in_sel;
    logic [7:0]            out_valid;
    logic [7:0]            out_ready;
    logic [8*DATA_W-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux32_1_8_buf.sv
// Registered 1-to-8 steering block. One producer word is routed to slot
// in_sel; each slot is a single-entry buffer with its own valid/ready.
// A full slot can be refilled in the same cycle its consumer drains it.
module demux32_1_8_buf #(
    parameter int DATA_W   = 32,
    parameter int CLR_DATA = 1
) (
    input  logic                clk,
    input  logic                rst,
    demux32_1_8_buf_if.slave    bus,
    output logic [3:0]          occupancy,
    output logic                busy
);
    logic [7:0]               full;
    logic [7:0]               full_nxt;
    logic [7:0]               drain;
    logic [7:0]               acc_vec;
    logic                     acc;
    logic [7:0][DATA_W-1:0]   data_q;

    function automatic logic [3:0] count8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Accept decision, per-slot drains and the next full vector.
    always_comb begin
        acc_vec      = 8'h00;
        bus.in_ready = ~full[bus.in_sel] | bus.out_ready[bus.in_sel];
        acc          = bus.in_valid & bus.in_ready;
        if (acc) begin
            acc_vec[bus.in_sel] = 1'b1;
        end
        drain    = full & bus.out_ready;
        full_nxt = (full & ~drain) | acc_vec;
    end

    // Slot valid flags and the occupancy count, kept equal to popcount(full).
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 8'h00;
            occupancy <= 4'd0;
        end else begin
            full      <= full_nxt;
            occupancy <= count8(full_nxt);
        end
    end

    // Slot data: loaded on accept, held otherwise (including across a drain).
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLR_DATA != 0) begin
                data_q <= '0;
            end
        end else if (acc) begin
            data_q[bus.in_sel] <= bus.in_data;
        end
    end

    assign bus.out_valid = full;
    assign bus.out_data  = data_q;
    assign busy          = (occupancy != 4'd0);
endmodule

// File: tb/tb_demux32_1_8_buf.sv
// Bench for the 1-to-8 steering block: directed scenarios followed by random
// traffic, all checked against a slot-level reference model.
module tb_demux32_1_8_buf;
    localparam int DATA_W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] occupancy;
    logic       busy;

    always #5 clk = ~clk;

    demux32_1_8_buf_if #(.DATA_W(DATA_W)) bus();

    demux32_1_8_buf #(.DATA_W(DATA_W), .CLR_DATA(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .occupancy (occupancy),
        .busy      (busy)
    );

    int          checks = 0;
    int          errors = 0;
    bit          m_full [8];
    logic [31:0] m_data [8];
    int          m_occ = 0;
    bit          m_known = 1'b0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready mid-cycle, then advance
    // the model and check every registered output just after the edge.
    task automatic step(input bit r, input bit v, input logic [2:0] sel,
                        input logic [31:0] d, input logic [7:0] rdy);
        bit           exp_rdy;
        bit           took;
        logic [7:0]   exp_valid;
        logic [255:0] exp_data;
        rst          = r;
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_data  = d;
        bus.out_ready = rdy;
        @(negedge clk);
        exp_rdy = !m_full[sel] || rdy[sel];
        if (m_known) check("in_ready", 256'(bus.in_ready), 256'(exp_rdy));
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < 8; k++) begin
                m_full[k] = 1'b0;
                m_data[k] = 32'h0;
            end
            m_occ   = 0;
            m_known = 1'b1;
        end else begin
            for (int k = 0; k < 8; k++) begin
                took = v && exp_rdy && (sel == 3'(k));
                if (took) begin
                    if (!m_full[k]) m_occ++;
                    m_full[k] = 1'b1;
                    m_data[k] = d;
                end else if (m_full[k] && rdy[k]) begin
                    m_full[k] = 1'b0;
                    m_occ--;
                end
            end
        end
        exp_valid = 8'h00;
        exp_data  = '0;
        for (int k = 0; k < 8; k++) begin
            exp_valid[k] = m_full[k];
            exp_data[k*32 +: 32] = m_data[k];
        end
        check("out_valid", 256'(bus.out_valid), 256'(exp_valid));
        check("occupancy", 256'(occupancy), 256'(m_occ));
        check("busy", 256'(busy), 256'(m_occ != 0));
        check("out_data", bus.out_data, exp_data);
    endtask

    initial begin
        logic [2:0]  rsel;
        logic [7:0]  rrdy;
        bit          rv;
        bit          rr;

        // reset, then idle with every select value
        step(1'b1, 1'b0, 3'd0, 32'h0, 8'h00);
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 1'b0, 3'(s), 32'h0, 8'h00);
            check("idle_in_ready", 256'(bus.in_ready), 256'(1));
        end
        check("reset_data_zero", bus.out_data, 256'h0);

        // single route to slot 5 and drain
        step(1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 8'h00);
        check("route5_valid", 256'(bus.out_valid), 256'(8'h20));
        check("route5_data", 256'(bus.out_data[191:160]), 256'(32'hDEADBEEF));
        check("route5_occ", 256'(occupancy), 256'(1));
        step(1'b0, 1'b0, 3'd0, 32'h0, 8'h20);
        check("drain5_valid", 256'(bus.out_valid), 256'(8'h00));
        check("drain5_occ", 256'(occupancy), 256'(0));

        // backpressure on slot 2
        step(1'b0, 1'b1, 3'd2, 32'hAAAA5555, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'd2, 32'h00001234, 8'h00);
            check("bp_blocked_data", 256'(bus.out_data[95:64]), 256'(32'hAAAA5555));
        end
        step(1'b0, 1'b1, 3'd2, 32'h00001234, 8'h04);
        check("bp_refill_data", 256'(bus.out_data[95:64]), 256'(32'h00001234));
        check("bp_refill_occ", 256'(occupancy), 256'(1));
        step(1'b0, 1'b0, 3'd0, 32'h0, 8'hFF);

        // fill all eight slots, then a ninth write is refused
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 3'(k), 32'(k + 100), 8'h00);
        end
        check("fill_occ", 256'(occupancy), 256'(8));
        step(1'b0, 1'b1, 3'd4, 32'hBAD0BAD0, 8'h00);
        check("fill_ninth_data", 256'(bus.out_data[159:128]), 256'(32'd104));
        step(1'b0, 1'b0, 3'd0, 32'h0, 8'hFF);

        // concurrent drain of 3 and 6 with accept to slot 0
        step(1'b0, 1'b1, 3'd1, 32'h11, 8'h00);
        step(1'b0, 1'b1, 3'd3, 32'h33, 8'h00);
        step(1'b0, 1'b1, 3'd6, 32'h66, 8'h00);
        step(1'b0, 1'b1, 3'd0, 32'h00C0FFEE, 8'b0100_1000);
        check("conc_valid", 256'(bus.out_valid), 256'(8'b0000_0011));
        check("conc_occ", 256'(occupancy), 256'(2));

        // reset with five full slots and a pending write
        step(1'b0, 1'b1, 3'd2, 32'h22, 8'h00);
        step(1'b0, 1'b1, 3'd4, 32'h44, 8'h00);
        step(1'b0, 1'b1, 3'd7, 32'h77, 8'h00);
        check("pre_rst_occ", 256'(occupancy), 256'(5));
        step(1'b1, 1'b1, 3'd5, 32'h55, 8'h00);
        check("mid_rst_valid", 256'(bus.out_valid), 256'(8'h00));
        check("mid_rst_occ", 256'(occupancy), 256'(0));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rr   = ($urandom_range(0, 199) == 0);
            rv   = ($urandom_range(0, 3) != 0);
            rsel = 3'($urandom_range(0, 7));
            rrdy = 8'($urandom) & 8'($urandom);
            step(rr, rv, rsel, $urandom, rrdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux32_1_8_buf.md
Name: demux32_1_8_buf

Overview:
- Registered 1-to-8 steering block: one 32-bit producer stream is routed to one of eight consumer slots by a 3-bit select.
- Each slot is a single-entry skid buffer with its own valid/ready handshake.
- Used wherever one result bus fans out to eight independent sinks (e.g. writeback distribution, per-unit response return).
- Inverse of the 8:1 32-bit selector used on the read side.

Parameters:
- DATA_W, 32, width of data path and of each slot register.
- CLR_DATA, 1, 1 = slot data registers reset to 0; 0 = data registers not reset (valids always reset).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  DATA_W  producer word
- in_sel  input  3  destination slot index 0..7
- out_valid  output  8  bit k: slot k holds a word
- out_ready  input  8  bit k: consumer k takes slot k's word this cycle
- out_data  output  8*DATA_W  slot k data on bits [k*DATA_W +: DATA_W]
- occupancy  output  4  number of full slots, 0..8
- busy  output  1  occupancy != 0

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=8'h00, occupancy=0, busy=0.
  - out_data=0 when CLR_DATA=1.
  - Reset overrides any simultaneous accept or drain.
- Slot k state: full_k (out_valid[k]) and data_k. No other state besides occupancy.
- Drain: drain_k = full_k & out_ready[k]. out_ready[k] is ignored while full_k=0.
- Accept:
  - in_ready = ~full[in_sel] | out_ready[in_sel]. This path is combinational from in_sel and out_ready.
  - acc = in_valid & in_ready; it targets only slot in_sel.
  - in_ready does not depend on in_valid.
- Slot update at posedge, per slot k:
  - acc to k: data_k <= in_data, full_k <= 1. This also covers simultaneous drain of k (pass-through refill; the old word is consumed by the consumer the same cycle).
  - else if drain_k: full_k <= 0; data_k holds its value.
  - else: hold.
- Latency: word accepted in cycle N appears on out_valid/out_data in cycle N+1. There is no combinational in_data→out_data path.
- Blocked: in_valid=1, slot in_sel full, out_ready[in_sel]=0 → in_ready=0 and no slot changes. The producer must hold in_data/in_sel stable until accepted (standard valid/ready; no retraction checking in RTL).
- Other slots drain independently in any cycle, including while the input is blocked on a different slot.
- Data stability: data_k is stable while full_k=1 and drain_k=0.
- occupancy:
  - Next value = occupancy + (acc & ~full[in_sel]) − (number of drain_k bits not refilled the same cycle).
  - Computed as the population count of next full vector; it must equal that.
  - Range 0..8, never wraps.
- in_sel is don't-care when in_valid=0. It still drives in_ready, which is not a functional concern.
- X-safety: out_valid and occupancy are never X after the first reset.

Test Plan:
- Reset then idle: rst high 1 cycle → out_valid=00, occupancy=0, busy=0, out_data=0; in_ready=1 for every in_sel.
- Single route: in_data=32'hDEADBEEF, in_sel=5, in_valid 1 cycle, out_ready=0 → next cycle out_valid=8'h20, out_data[191:160]=DEADBEEF, occupancy=1. Then out_ready[5]=1 for 1 cycle → out_valid=00, occupancy=0.
- Backpressure: slot 2 full, out_ready[2]=0, in_valid=1, in_sel=2, in_data=32'h1234 → in_ready=0 for 3 cycles, slot 2 data unchanged. Raise out_ready[2] → in_ready=1 that cycle, next cycle slot 2 = 32'h1234, out_valid[2]=1, occupancy unchanged.
- Fill all: write slots 0..7 with values k+100, out_ready=0 → occupancy reaches 8 after 8 cycles. A ninth write to any sel shows in_ready=0.
- Concurrent: slots 1,3,6 full; in the same cycle out_ready=8'b0100_1000 (drain 3,6) and accept to slot 0 → next out_valid=8'b0000_0011, occupancy=2.
- Reset mid-operation: occupancy=5 with in_valid=1 and rst=1 in the same cycle → next cycle out_valid=00, occupancy=0, no accept.
